// File: rtl/scale_mux_arbiter.sv
// Two-requester round-robin arbiter driving a registered 2:1 mux select and a
// registered valid/ready output stage, with a burst limit per grant.
module scale_mux_arbiter #(
  parameter int SIZE  = 8,
  parameter int BURST = 4
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [SIZE-1:0] A,
  input  logic            REQ_A,
  output logic            ACK_A,
  input  logic [SIZE-1:0] B,
  input  logic            REQ_B,
  output logic            ACK_B,
  output logic            SEL,
  output logic [SIZE-1:0] OUT,
  output logic            OUT_VALID,
  input  logic            OUT_READY
);

  localparam int CW = $clog2(BURST) + 1;
  localparam logic [CW-1:0] CntMax = CW'(BURST - 1);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

  state_t          state_q, state_d;
  logic            sel_q, sel_d;
  logic [SIZE-1:0] out_q, out_d;
  logic            valid_q, valid_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_q, last_d;
  logic            space;

  assign space     = !valid_q || OUT_READY;
  assign ACK_A     = RST_N && (state_q == GRANT_A) && REQ_A && space;
  assign ACK_B     = RST_N && (state_q == GRANT_B) && REQ_B && space;
  assign SEL       = sel_q;
  assign OUT       = out_q;
  assign OUT_VALID = valid_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (REQ_A && (!REQ_B || last_q)) begin
          state_d = GRANT_A;
          last_d  = 1'b0;
          cnt_d   = '0;
        end else if (REQ_B) begin
          state_d = GRANT_B;
          last_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT_A: begin
        if (!REQ_A) begin
          cnt_d   = '0;
          state_d = REQ_B ? GRANT_B : IDLE;
          if (REQ_B) last_d = 1'b1;
        end else if (ACK_A) begin
          if (cnt_q == CntMax) begin
            cnt_d = '0;
            if (REQ_B) begin
              state_d = GRANT_B;
              last_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      GRANT_B: begin
        if (!REQ_B) begin
          cnt_d   = '0;
          state_d = REQ_A ? GRANT_A : IDLE;
          if (REQ_A) last_d = 1'b0;
        end else if (ACK_B) begin
          if (cnt_q == CntMax) begin
            cnt_d = '0;
            if (REQ_A) begin
              state_d = GRANT_A;
              last_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    sel_d = (state_d == GRANT_B);
  end

  // Output stage: a transfer loads new data; otherwise a consumed word drains.
  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    if (ACK_A) begin
      out_d   = A;
      valid_d = 1'b1;
    end else if (ACK_B) begin
      out_d   = B;
      valid_d = 1'b1;
    end else if (OUT_READY) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_scale_mux_arbiter.sv
// Randomized and directed bench for scale_mux_arbiter against a grant/burst
// reference model.
module tb_scale_mux_arbiter;

  localparam int SIZE  = 8;
  localparam int BURST = 4;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic [SIZE-1:0] A, B;
  logic            REQ_A, REQ_B, OUT_READY;
  logic            ACK_A, ACK_B, SEL, OUT_VALID;
  logic [SIZE-1:0] OUT;

  scale_mux_arbiter #(.SIZE(SIZE), .BURST(BURST)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .A(A), .REQ_A(REQ_A), .ACK_A(ACK_A),
    .B(B), .REQ_B(REQ_B), .ACK_B(ACK_B),
    .SEL(SEL), .OUT(OUT), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the mux (0 none, 1 A, 2 B), transfers used in
  // the current burst, who won last, and the word sitting in the output stage.
  int              owner;
  int              used;
  bit              lastWasB;
  logic [SIZE-1:0] mOut;
  bit              mValid;
  bit              modelReady = 0;
  bit              seenAckA, seenAckB;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit ra, input bit rb,
                               input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                               input bit rdy);
    bit expAckA, expAckB, space, myReq, otherReq;
    @(negedge CLK);
    RST_N = rst; REQ_A = ra; REQ_B = rb; A = a; B = b; OUT_READY = rdy;
    #1;
    space   = !mValid || rdy;
    expAckA = rst && modelReady && owner == 1 && ra && space;
    expAckB = rst && modelReady && owner == 2 && rb && space;
    seenAckA = ACK_A;
    seenAckB = ACK_B;
    if (modelReady) begin
      checkOutput("ackA", 32'(ACK_A), 32'(expAckA));
      checkOutput("ackB", 32'(ACK_B), 32'(expAckB));
      checkOutput("sel", 32'(SEL), 32'(owner == 2));
      checkOutput("outValid", 32'(OUT_VALID), 32'(mValid));
      checkOutput("out", 32'(OUT), 32'(mOut));
    end
    if (!rst) begin
      owner = 0; used = 0; lastWasB = 1; mOut = '0; mValid = 0;
      modelReady = 1;
    end else if (modelReady) begin
      if (expAckA) begin
        mOut = a; mValid = 1;
      end else if (expAckB) begin
        mOut = b; mValid = 1;
      end else if (rdy) begin
        mValid = 0;
      end
      if (owner == 0) begin
        if (ra && rb) owner = lastWasB ? 1 : 2;
        else if (ra) owner = 1;
        else if (rb) owner = 2;
        if (owner != 0) begin
          lastWasB = (owner == 2);
          used = 0;
        end
      end else begin
        myReq    = (owner == 1) ? ra : rb;
        otherReq = (owner == 1) ? rb : ra;
        if (!myReq) begin
          used  = 0;
          owner = otherReq ? 3 - owner : 0;
          if (owner != 0) lastWasB = (owner == 2);
        end else if (expAckA || expAckB) begin
          used++;
          if (used == BURST) begin
            used = 0;
            if (otherReq) begin
              owner = 3 - owner;
              lastWasB = (owner == 2);
            end
          end
        end
      end
    end
  endtask

  initial begin
    logic [11:0] pattern;
    int          ackCount;
    RST_N = 0; REQ_A = 0; REQ_B = 0; A = '0; B = '0; OUT_READY = 0;
    owner = 0; used = 0; lastWasB = 1; mOut = '0; mValid = 0;

    // Reset held with both requesting, then continuous contention.
    applyStimulus(0, 1, 1, 8'h11, 8'h22, 1);
    applyStimulus(0, 1, 1, 8'h11, 8'h22, 1);
    applyStimulus(1, 1, 1, 8'h11, 8'h22, 1);
    checkOutput("arbCycleNoAck", 32'(seenAckA | seenAckB), 32'd0);
    pattern = '0;
    ackCount = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 1, 1, 8'(8'h40 + i), 8'(8'h80 + i), 1);
      pattern[i] = seenAckB;
      ackCount += int'(seenAckA) + int'(seenAckB);
    end
    checkOutput("burstPattern", 32'(pattern), 32'(12'b0000_1111_0000));
    checkOutput("noIdleGaps", 32'(ackCount), 32'd12);

    // Single requester A.
    applyStimulus(0, 0, 0, 8'h00, 8'h00, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 8'h3C, 8'h00, 1);

    // Backpressure during contention.
    for (int i = 0; i < 24; i++) applyStimulus(1, 1, 1, 8'($urandom), 8'($urandom), (i % 3) != 0);

    // Requester drop in GRANT_B, then simultaneous request goes to A.
    applyStimulus(0, 0, 0, 8'h00, 8'h00, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 8'h55, 8'hB0, 1);
    applyStimulus(1, 0, 0, 8'h55, 8'hB1, 1);
    applyStimulus(1, 0, 0, 8'h55, 8'hB2, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 8'hA7, 8'hB3, 1);

    // Mid-burst reset with OUT held valid.
    applyStimulus(0, 0, 0, 8'h00, 8'h00, 1);
    applyStimulus(1, 0, 1, 8'h00, 8'hC9, 1);
    applyStimulus(1, 0, 1, 8'h00, 8'hC9, 0);
    applyStimulus(1, 0, 1, 8'h00, 8'hCA, 0);
    applyStimulus(0, 0, 1, 8'h00, 8'hCA, 0);
    applyStimulus(1, 0, 0, 8'h00, 8'hCA, 1);
    applyStimulus(1, 0, 0, 8'h00, 8'hCA, 1);

    // Random traffic with occasional reset.
    for (int i = 0; i < 3000; i++)
      applyStimulus($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
                    $urandom_range(0, 3) != 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scale_mux_arbiter.md
Name: scale_mux_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the shared scalable 2:1 multiplexer datapath. It handshakes with requesters A and B and drives the mux select with a never-X registered SEL. The selected operand is captured into a registered output stage with valid/ready flow control. A burst limit bounds how long one requester may hold the mux while the other is waiting.

Parameters:
SIZE, 8, data width of A, B and OUT; must be >= 1.
BURST, 4, maximum consecutive transfers granted to one requester while the other is requesting; must be >= 1.

Ports:
CLK  input  1  rising-edge clock.
RST_N  input  1  synchronous reset, active-low, sampled on the rising edge of CLK.
A  input  SIZE  requester A operand.
REQ_A  input  1  requester A holds data valid.
ACK_A  output  1  requester A transfer accepted this cycle.
B  input  SIZE  requester B operand.
REQ_B  input  1  requester B holds data valid.
ACK_B  output  1  requester B transfer accepted this cycle.
SEL  output  1  mux select: 0 selects A, 1 selects B. Registered.
OUT  output  SIZE  registered selected operand.
OUT_VALID  output  1  OUT holds valid data.
OUT_READY  input  1  downstream accepts OUT this cycle.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-low (RST_N).
- RST_N low at a CLK edge forces:
  - state=IDLE, SEL=0, OUT=0, OUT_VALID=0
  - burst count CNT=0, LAST=B (so A wins the first tie)
  - ACK_A=ACK_B=0 while RST_N is low.
- Reset asserted mid-burst or mid-transfer discards the pending OUT data. No partial state survives reset.
- States:
  - IDLE: SEL=0.
  - GRANT_A: SEL=0.
  - GRANT_B: SEL=1.
  - SEL is a register and is updated on the same edge as the state.
- Output space: SPACE = !OUT_VALID | OUT_READY.
- Acknowledges (combinational from state, REQ and SPACE):
  - ACK_A = (state==GRANT_A) & REQ_A & SPACE.
  - ACK_B = (state==GRANT_B) & REQ_B & SPACE.
  - IDLE never acknowledges.
- Transfer: REQ_x & ACK_x at an edge.
  - OUT <= x operand, OUT_VALID <= 1.
  - Back-to-back transfers every cycle are allowed while OUT_READY=1.
- Drain: OUT_VALID & OUT_READY with no transfer at that edge gives OUT_VALID <= 0; OUT keeps its last value.
- Stall: OUT_VALID & !OUT_READY holds OUT and OUT_VALID stable, and both ACKs are 0.
- IDLE arbitration:
  - Only REQ_A high: go to GRANT_A.
  - Only REQ_B high: go to GRANT_B.
  - Both high: grant the requester that is not LAST.
  - Neither high: stay in IDLE.
  - Arbitration costs one cycle: the first ACK comes at the earliest 1 cycle after REQ is first sampled in IDLE.
  - On entering GRANT_x: LAST <= x, CNT <= 0.
- In GRANT_x (y = the other requester):
  - REQ_x low: go to GRANT_y if REQ_y is high (LAST <= y, CNT <= 0), else go to IDLE. CNT is cleared.
  - Transfer with CNT==BURST-1 and REQ_y high: go to GRANT_y, CNT <= 0, LAST <= y.
  - Transfer with CNT==BURST-1 and REQ_y low: stay in GRANT_x, CNT <= 0.
  - Other transfers: CNT <= CNT+1.
  - No transfer (stall): CNT holds.
- Switching GRANT_A to GRANT_B and back costs no idle cycle. The new grantee's ACK can assert on the first cycle in its state.
- CNT width is clog2(BURST)+1 and CNT never exceeds BURST-1. With BURST=1, requesters strictly alternate when both are requesting.
- SEL changes only on state transitions and is never X after reset.

Test Plan:
- Reset: hold RST_N=0 for 2 cycles with REQ_A=REQ_B=1 -> SEL=0, OUT=0, OUT_VALID=0, ACK_A=ACK_B=0. On release, the first grant goes to A.
- Single requester A: A=8'h3C, REQ_A=1, OUT_READY=1 -> ACK_A high 1 cycle after the request, then OUT=8'h3C, OUT_VALID=1 on the next edge. Repeated transfers every cycle with no switch.
- Contention (BURST=4, both requesting continuously, OUT_READY=1) -> ACK pattern A,A,A,A,B,B,B,B,A… SEL toggles every 4 transfers with no idle cycle between grants.
- Backpressure: OUT_READY=0 while OUT_VALID=1 -> OUT stable, ACK_A=ACK_B=0, CNT frozen. After OUT_READY=1 the transfer resumes, and the burst boundary still falls at exactly 4 transfers.
- Requester drop: in GRANT_B after 2 transfers, drop REQ_B with REQ_A=0 -> IDLE next cycle with SEL=0. Then assert REQ_A and REQ_B together -> grant goes to A (LAST=B).
- Mid-burst reset: assert RST_N=0 in GRANT_B with OUT_VALID=1 -> next edge OUT_VALID=0, SEL=0, state IDLE; the stale data is not re-presented.
